// File: rtl/nmr_param_bank.sv
// nmr_param_bank
// Double-buffered NMR pulse-parameter bank behind an Avalon-MM slave port.
// Software writes the shadow registers and then issues COMMIT. The shadow
// set is copied to the active registers in one single-cycle APPLY step.
// That copy waits while the pulse sequencer is busy, so a running sequence
// never sees a half-updated parameter set. DISCARD restores shadow from
// active.
//
// Ports:
//   clk, reset_n          - rising-edge clock, asynchronous active-low reset
//   chipselect, write_n   - Avalon-MM select and active-low write strobe
//   address               - word address (shadow, active, CTRL, STATUS)
//   writedata, readdata   - 32-bit bus data; reads are combinational
//   byteenable            - only present with NMR_PARAM_BANK_BYTEEN_EN
//   seq_busy              - sequencer running; defers a commit
//   out_port              - active registers, channel k at [k*DATA_W +: DATA_W]
//   commit_ack            - high for the single APPLY cycle
//
// Configuration macro: NMR_PARAM_BANK_BYTEEN_EN adds per-byte write enables.

module nmr_param_bank #(
    parameter int DATA_W = 32,
    parameter int NCH    = 8,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chipselect,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
`ifdef NMR_PARAM_BANK_BYTEEN_EN
    input  logic [3:0]            byteenable,
`endif
    output logic [31:0]           readdata,
    input  logic                  seq_busy,
    output logic [NCH*DATA_W-1:0] out_port,
    output logic                  commit_ack
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_APPLY   = 2'd2;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(2 * NCH);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(2 * NCH + 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        commit_cnt_q, commit_cnt_d;
    logic [DATA_W-1:0] shadow_q [NCH];
    logic [DATA_W-1:0] shadow_d [NCH];
    logic [DATA_W-1:0] active_q [NCH];
    logic [DATA_W-1:0] active_d [NCH];

    logic        wr_en;
    logic        ctrl_wr;
    logic        do_commit;
    logic        do_discard;
    logic        discard_copy;
    logic        ctrl_be_ok;
    logic [31:0] wr_mask;

    // Per-bit write mask for shadow writes. CTRL is only acted on when its
    // low byte is enabled, because the COMMIT and DISCARD bits live there.
    always_comb begin
        wr_mask    = '1;
        ctrl_be_ok = 1'b1;
`ifdef NMR_PARAM_BANK_BYTEEN_EN
        for (int b = 0; b < 4; b++) begin
            wr_mask[b*8 +: 8] = {8{byteenable[b]}};
        end
        ctrl_be_ok = byteenable[0];
`endif
    end

    assign wr_en      = chipselect & ~write_n;
    assign ctrl_wr    = wr_en && (address == CTRL_ADDR) && ctrl_be_ok;
    // DISCARD wins when both bits are written together.
    assign do_discard = ctrl_wr & writedata[1];
    assign do_commit  = ctrl_wr & writedata[0] & ~writedata[1];

    always_comb begin
        state_d      = state_q;
        commit_cnt_d = commit_cnt_q;
        discard_copy = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
        end

        for (int k = 0; k < NCH; k++) begin
            if (wr_en && (address == ADDR_W'(k))) begin
                shadow_d[k] = (shadow_q[k] & ~wr_mask[DATA_W-1:0])
                            | (writedata[DATA_W-1:0] & wr_mask[DATA_W-1:0]);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (do_discard) begin
                    discard_copy = 1'b1;
                end else if (do_commit) begin
                    state_d = seq_busy ? ST_PENDING : ST_APPLY;
                end
            end
            ST_PENDING: begin
                if (do_discard) begin
                    discard_copy = 1'b1;
                    state_d      = ST_IDLE;
                end else if (!seq_busy) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                // Copy from the registered shadow values. A bus write in this
                // same cycle therefore lands in shadow only.
                for (int k = 0; k < NCH; k++) begin
                    active_d[k] = shadow_q[k];
                end
                commit_cnt_d = commit_cnt_q + 8'd1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A discard and a shadow write never coincide, since both come from
        // the one bus. Letting the discard override keeps the intent obvious.
        if (discard_copy) begin
            for (int k = 0; k < NCH; k++) begin
                shadow_d[k] = active_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            commit_cnt_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            commit_cnt_q <= commit_cnt_d;
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    // The live seq_busy bit is masked during reset so that every address
    // reads zero while reset_n is low.
    always_comb begin
        readdata = '0;
        for (int k = 0; k < NCH; k++) begin
            if (address == ADDR_W'(k)) begin
                readdata = 32'(shadow_q[k]);
            end
            if (address == ADDR_W'(NCH + k)) begin
                readdata = 32'(active_q[k]);
            end
        end
        if (address == STATUS_ADDR) begin
            readdata = {16'd0, commit_cnt_q, 6'd0, seq_busy & reset_n,
                        (state_q == ST_PENDING) || (state_q == ST_APPLY)};
        end
    end

    assign commit_ack = (state_q == ST_APPLY);

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign out_port[k*DATA_W +: DATA_W] = active_q[k];
    end

endmodule

// File: doc/nmr_param_bank.md
NMR_PARAM_BANK -- requirements
Module: nmr_param_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each parameter channel (legal range 1..32).
REQ-002 SHALL have parameter NCH, default 8, meaning the number of parameter channels (legal range 1..16).
REQ-003 SHALL have parameter ADDR_W, default 5, meaning the word address width; 2^ADDR_W >= 2*NCH+2 is required.
REQ-004 SHALL have port clk, input, 1, system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL have port address, input, ADDR_W, word address.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, write data.
REQ-010 SHALL have port readdata, output, 32, read data.
REQ-011 SHALL have port seq_busy, input, 1, pulse sequencer running; synchronous to clk.
REQ-012 SHALL have port out_port, output, NCH*DATA_W, active registers flattened; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port commit_ack, output, 1, one-cycle pulse when active registers update.

Function
REQ-014 SHALL use this address map:
  - 0..NCH-1: shadow[k], read/write.
  - NCH..2*NCH-1: active[k-NCH], read-only.
  - 2*NCH: CTRL, write-only; bit0 = COMMIT, bit1 = DISCARD.
  - 2*NCH+1: STATUS, read-only; bit0 = pending, bit1 = seq_busy, bits[15:8] = commit_cnt.
REQ-015 SHALL perform a write when chipselect=1 and write_n=0; a shadow write stores writedata[DATA_W-1:0] on the next clock edge.
REQ-016 SHALL ignore writes to read-only or unmapped addresses, with no side effect.
REQ-017 SHALL drive readdata combinationally with zero wait states: selected value zero-extended to 32 bits, CTRL and unmapped addresses read 0.
REQ-018 SHALL implement an FSM with states IDLE, PENDING and APPLY.
REQ-019 SHALL, in IDLE, on a CTRL write with COMMIT=1 and DISCARD=0: go to APPLY if seq_busy=0, else go to PENDING.
REQ-020 SHALL, in PENDING, go to APPLY on the first cycle with seq_busy=0.
REQ-021 SHALL, in APPLY (exactly one cycle):
  - copy all shadow values, as registered at the start of the cycle, to active on that cycle's closing edge;
  - assert commit_ack for that cycle;
  - increment commit_cnt (8-bit, wraps 255->0);
  - return to IDLE.
REQ-022 SHALL not pass a shadow write issued during the APPLY cycle to active; it updates shadow only.
REQ-023 SHALL accept shadow writes during PENDING; the value present when APPLY is entered is the one committed.
REQ-024 SHALL ignore COMMIT while in PENDING or APPLY; requests merge and no second apply occurs.
REQ-025 SHALL, on DISCARD=1 in IDLE or PENDING, copy active to all shadow registers, go to (or stay in) IDLE, and cancel any pending commit.
REQ-026 SHALL ignore DISCARD in APPLY.
REQ-027 SHALL give DISCARD priority when COMMIT=1 and DISCARD=1 are written together: discard behaviour only.
REQ-028 SHALL give the DISCARD copy priority over a simultaneous shadow write only when the two target the same cycle; since both come from one bus, this cannot occur.
REQ-029 SHALL set the STATUS pending bit to 1 exactly when the FSM is in PENDING or APPLY.
REQ-030 SHALL drive out_port combinationally from the active registers only; shadow changes never reach out_port except through APPLY.

Reset
REQ-031 SHALL, on reset_n=0, asynchronously clear shadow, active and commit_cnt to 0, force the FSM to IDLE and drive commit_ack=0.
REQ-032 SHALL drop a pending commit on reset mid-operation; after release, out_port=0 until a new commit.
REQ-033 SHALL drive readdata combinationally from reset state, reading 0 for every address during reset.

Configuration
REQ-034 SHALL, when macro NMR_PARAM_BANK_BYTEEN_EN is defined:
  - add input byteenable, 4 bits;
  - update only the bytes of a shadow write whose byteenable bit is 1 (bytes above DATA_W ignored);
  - act on a CTRL write only if byteenable[0]=1.
REQ-035 SHALL, when NMR_PARAM_BANK_BYTEEN_EN is undefined, have no byteenable port and treat every write as a full-word write.

Verification
REQ-036 SHALL cover basic commit (NCH=8, DATA_W=32): write shadow[3]=0xDEADBEEF, seq_busy=0, write CTRL=0x1 -> commit_ack pulses 1 cycle later, out_port[127:96]=0xDEADBEEF, STATUS[15:8]=1.
REQ-037 SHALL cover deferred commit: seq_busy=1, write shadow[0]=0x10, COMMIT, then shadow[0]=0x20 -> STATUS.pending=1, out_port unchanged; drop seq_busy -> next cycle commit_ack=1, active[0]=0x20.
REQ-038 SHALL cover discard while pending: shadow[1]=0x55 with active[1]=0x11, seq_busy=1, COMMIT then CTRL=0x2 -> pending=0, shadow[1] reads 0x11, no commit_ack after seq_busy drops.
REQ-039 SHALL cover simultaneous bits and counter wrap: CTRL=0x3 -> no commit; 256 commits -> commit_cnt reads 0.
REQ-040 SHALL cover reset mid-pending: seq_busy=1, COMMIT, assert reset_n=0 for 1 cycle -> all reads 0, FSM IDLE, no commit_ack after seq_busy=0.
REQ-041 SHALL cover byte enables with NMR_PARAM_BANK_BYTEEN_EN defined: shadow[2]=0xAABBCCDD, write 0x11223344 with byteenable=0x5 -> shadow[2] reads 0xAA22CC44.
